// File: rtl/ecc_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : ecc_host_seq
// Purpose  : Host-side sequencer for the ECC core. Loads operands one byte at
//            a time, runs one operation (clear pulse, enable pulse, ready
//            handshake with timeout), captures the x/y results and streams
//            them back out as bytes.
// Ports    : clk/rst             - clock, synchronous active-high reset
//            ld_valid/sel/data   - byte-serial operand load (MSB-first)
//            start/op            - command pulse and operation code
//            busy/done/err       - status (done and err are sticky)
//            rd_valid/ready/data - result byte stream, x then y, MSB-first
//            ecc_op/en/clr/rdy   - ECC core control handshake
//            Qx..hash_msg        - operand registers to the core
//            x, y                - results from the core
// Revision : 1.0 - initial release
// ============================================================================
module ecc_host_seq #(
    parameter int WIDTH     = 256,
    parameter int TO_CYCLES = 1048576,
    parameter int TO_W      = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [2:0]       ld_sel,
    input  logic [7:0]       ld_data,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic [1:0]       ecc_op,
    output logic             ecc_en,
    output logic             ecc_clr,
    input  logic             ecc_rdy,
    output logic [WIDTH-1:0] Qx,
    output logic [WIDTH-1:0] Qy,
    output logic [WIDTH-1:0] in_kr,
    output logic [WIDTH-1:0] in_ds,
    output logic [WIDTH-1:0] hash_msg,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y
);

    localparam int                 c_n_bytes  = 2 * WIDTH / 8;
    localparam int                 c_idx_w    = $clog2(c_n_bytes);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_n_bytes - 1);
    localparam logic [TO_W-1:0]    c_to_last  = TO_W'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_EN   = 3'd2,
        S_WLO  = 3'd3,
        S_WHI  = 3'd4,
        S_RD   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_qx;
    logic [WIDTH-1:0]     r_qy;
    logic [WIDTH-1:0]     r_in_kr;
    logic [WIDTH-1:0]     r_in_ds;
    logic [WIDTH-1:0]     r_hash_msg;
    logic [1:0]           r_ecc_op;
    logic                 r_err;
    logic [TO_W-1:0]      r_to_cnt;
    logic [2*WIDTH-1:0]   r_res;
    logic [c_idx_w-1:0]   r_rd_idx;

    logic                 w_idle_like;
    logic                 w_start_acc;
    logic                 w_ld_en;
    logic                 w_waiting;
    logic                 w_timeout;
    logic                 w_capture;
    logic                 w_rd_fire;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_rd_valid;
    logic                 w_ecc_en;
    logic                 w_ecc_clr;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_acc = start && w_idle_like;
    assign w_ld_en     = ld_valid && w_idle_like && (ld_sel <= 3'd4);
    assign w_waiting   = (r_state == S_WLO) || (r_state == S_WHI);
    assign w_capture   = (r_state == S_WHI) && ecc_rdy;
    assign w_rd_fire   = w_rd_valid && rd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs. In the wait states a handshake
    // transition on the final budget cycle wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_valid  = 1'b0;
        w_ecc_en    = 1'b0;
        w_ecc_clr   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLR;
            end
            S_CLR: begin
                w_busy      = 1'b1;
                w_ecc_clr   = 1'b1;
                w_state_nxt = S_EN;
            end
            S_EN: begin
                w_busy      = 1'b1;
                w_ecc_en    = 1'b1;
                w_state_nxt = S_WLO;
            end
            S_WLO: begin
                w_busy = 1'b1;
                if (!ecc_rdy) begin
                    w_state_nxt = S_WHI;
                end else if (r_to_cnt == c_to_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WHI: begin
                w_busy = 1'b1;
                if (ecc_rdy) begin
                    w_state_nxt = S_RD;
                end else if (r_to_cnt == c_to_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_busy     = 1'b1;
                w_rd_valid = 1'b1;
                if (rd_ready && (r_rd_idx == c_idx_last)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) w_state_nxt = S_CLR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand, status and result datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qx       <= '0;
            r_qy       <= '0;
            r_in_kr    <= '0;
            r_in_ds    <= '0;
            r_hash_msg <= '0;
            r_ecc_op   <= '0;
            r_err      <= 1'b0;
            r_to_cnt   <= '0;
            r_res      <= '0;
            r_rd_idx   <= '0;
        end else begin
            if (w_ld_en) begin
                case (ld_sel)
                    3'd0:    r_qx       <= {r_qx[WIDTH-9:0], ld_data};
                    3'd1:    r_qy       <= {r_qy[WIDTH-9:0], ld_data};
                    3'd2:    r_in_kr    <= {r_in_kr[WIDTH-9:0], ld_data};
                    3'd3:    r_in_ds    <= {r_in_ds[WIDTH-9:0], ld_data};
                    3'd4:    r_hash_msg <= {r_hash_msg[WIDTH-9:0], ld_data};
                    default: ;
                endcase
            end

            if (w_start_acc) begin
                r_ecc_op <= op;
                r_err    <= 1'b0;
            end
            if (w_timeout) r_err <= 1'b1;

            // One budget spans both wait states; it restarts only in EN.
            if (r_state == S_EN) begin
                r_to_cnt <= '0;
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            // Results live in one shift register; the top byte is always
            // the byte on offer, so it cannot change while stalled.
            if (w_capture) begin
                r_res    <= {x, y};
                r_rd_idx <= '0;
            end else if (w_rd_fire) begin
                r_res    <= {r_res[2*WIDTH-9:0], 8'h00};
                r_rd_idx <= r_rd_idx + c_idx_w'(1);
            end
        end
    end

    assign busy     = w_busy;
    assign done     = w_done;
    assign err      = r_err;
    assign rd_valid = w_rd_valid;
    assign rd_data  = r_res[2*WIDTH-1 -: 8];
    assign ecc_op   = r_ecc_op;
    assign ecc_en   = w_ecc_en;
    assign ecc_clr  = w_ecc_clr;
    assign Qx       = r_qx;
    assign Qy       = r_qy;
    assign in_kr    = r_in_kr;
    assign in_ds    = r_in_ds;
    assign hash_msg = r_hash_msg;

endmodule
`default_nettype wire

// File: tb/tb_ecc_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_host_seq
// Purpose  : Self-checking bench for ecc_host_seq. A transaction-level model
//            (operand arrays, an operation-cycle counter and a byte queue)
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_host_seq;

    localparam int W   = 256;
    localparam int TO  = 16;
    localparam int TOW = 5;
    localparam int NB  = 2 * W / 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld_valid = 1'b0;
    logic [2:0]   ld_sel = 3'd0;
    logic [7:0]   ld_data = 8'd0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic         busy, done, err, rd_valid;
    logic         rd_ready = 1'b0;
    logic [7:0]   rd_data;
    logic [1:0]   ecc_op;
    logic         ecc_en, ecc_clr;
    logic         ecc_rdy = 1'b1;
    logic [W-1:0] Qx, Qy, in_kr, in_ds, hash_msg;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;

    always #5 clk = ~clk;

    ecc_host_seq #(.WIDTH(W), .TO_CYCLES(TO), .TO_W(TOW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data),
        .start(start), .op(op),
        .busy(busy), .done(done), .err(err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ecc_op(ecc_op), .ecc_en(ecc_en), .ecc_clr(ecc_clr), .ecc_rdy(ecc_rdy),
        .Qx(Qx), .Qy(Qy), .in_kr(in_kr), .in_ds(in_ds), .hash_msg(hash_msg),
        .x(x), .y(y)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_opnd [5];
    bit           m_run, m_done, m_err, m_seen_low;
    logic [1:0]   m_op;
    int           m_t, m_wait;
    logic [7:0]   m_q [$];

    task automatic model_step();
        logic [2*W-1:0] xy;
        bit moved;
        if (rst) begin
            for (int i = 0; i < 5; i++) m_opnd[i] = '0;
            m_run = 0; m_done = 0; m_err = 0; m_seen_low = 0;
            m_op = 2'd0; m_t = 0; m_wait = 0; m_q.delete();
        end else begin
            if (!m_run && ld_valid && ld_sel <= 3'd4)
                m_opnd[int'(ld_sel)] = (m_opnd[int'(ld_sel)] << 8) | W'(ld_data);
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_t = 1; m_op = op; m_done = 0; m_err = 0; m_q.delete();
                end
            end else if (m_t < 3) begin
                m_t++; m_wait = 0; m_seen_low = 0;
            end else if (m_q.size() != 0) begin
                if (rd_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin m_run = 0; m_done = 1; end
                end
            end else begin
                moved = m_seen_low ? ecc_rdy : !ecc_rdy;
                if (moved) begin
                    if (m_seen_low) begin
                        xy = {x, y};
                        for (int i = 0; i < NB; i++) m_q.push_back(xy[8*(NB-1-i) +: 8]);
                    end
                    m_seen_low = 1;
                end else if (m_wait == TO - 1) begin
                    m_run = 0; m_err = 1;
                end
                m_wait++;
            end
        end
    endtask

    task automatic compare();
        chk("busy", W'(busy), W'(m_run));
        chk("done", W'(done), W'(m_done));
        chk("err", W'(err), W'(m_err));
        chk("rd_valid", W'(rd_valid), W'(m_q.size() != 0));
        chk("ecc_clr", W'(ecc_clr), W'(m_run && m_t == 1));
        chk("ecc_en", W'(ecc_en), W'(m_run && m_t == 2));
        chk("ecc_op", W'(ecc_op), W'(m_op));
        chk("Qx", Qx, m_opnd[0]);
        chk("Qy", Qy, m_opnd[1]);
        chk("in_kr", in_kr, m_opnd[2]);
        chk("in_ds", in_ds, m_opnd[3]);
        chk("hash_msg", hash_msg, m_opnd[4]);
        if (m_q.size() != 0) chk("rd_data", W'(rd_data), W'(m_q[0]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] got_q [$];
    int t_clr, t_en, t_rise, t_rdv, t_err, n_clr, n_en, t_first, t_last;
    bit e1;

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_loads(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_sel = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // One operation; the core drops ecc_rdy for 'low' cycles after enable
    // (never, when drop is clear) and then raises it again.
    task automatic run_op(input logic [1:0] o, input bit drop, input int low,
                          input int rmode, input bit noise, input bit ld_with_start);
        int k;
        bit ph, ended;
        got_q.delete();
        t_clr = -1; t_en = -1; t_rise = -1; t_rdv = -1; t_err = -1;
        n_clr = 0; n_en = 0; t_first = -1; t_last = -1; e1 = 1'b1;
        k = 0; ph = 0; ended = 0;
        @(negedge clk);
        start = 1'b1; op = o; ecc_rdy = 1'b1;
        if (ld_with_start) begin
            ld_valid = 1'b1; ld_sel = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
        end
        for (int j = 1; j <= 3000; j++) begin
            @(negedge clk);
            start = 1'b0; ld_valid = 1'b0;
            if (j == 1) e1 = err;
            if (ecc_clr) begin n_clr++; if (t_clr < 0) t_clr = j; end
            if (ecc_en) begin n_en++; if (t_en < 0) t_en = j; ph = 1; end
            if (err && t_err < 0) t_err = j;
            if (rd_valid && t_rdv < 0) t_rdv = j;
            if (j > 1 && !busy) begin ended = 1; break; end
            if (ph) begin
                ecc_rdy = !(drop && k < low);
                if (drop && low > 0 && k == low) t_rise = j;
                k++;
            end
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (j % 2) == 0;
                default: rd_ready = $urandom_range(0, 3) != 0;
            endcase
            if (noise) begin
                start = $urandom_range(0, 1) == 1;
                ld_valid = 1'b1; ld_sel = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
            end
            if (rd_valid && rd_ready) begin
                got_q.push_back(rd_data);
                if (t_first < 0) t_first = j;
                t_last = j;
            end
        end
        rd_ready = 1'b0; ecc_rdy = 1'b1; start = 1'b0; ld_valid = 1'b0;
        if (!ended) begin
            n_checks++; n_fail++;
            $display("FAIL op_bound actual=still_busy required=idle");
        end
        chk("op_end", W'(done | err), W'(1));
    endtask

    localparam logic [W-1:0] QX_LIT =
        256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

    initial begin
        int cnt;
        logic [2*W-1:0] xy;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_rd_valid", W'(rd_valid), W'(0));
        chk("rst_ecc_en", W'(ecc_en | ecc_clr), W'(0));
        chk("rst_Qx", Qx, '0);
        rst = 1'b0;

        // Load 0x01..0x20 into Qx
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_sel = 3'd0; ld_data = 8'(i);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        chk("load_Qx", Qx, QX_LIT);
        chk("load_model_Qx", m_opnd[0], QX_LIT);
        chk("load_Qy", Qy, '0);
        chk("load_busy", W'(busy), W'(0));

        // Sequence, capture and full-rate readout
        x = {32{8'hAA}}; y = {32{8'h55}};
        run_op(2'b10, 1'b1, 5, 0, 1'b0, 1'b0);
        chk("seq_t_clr", W'(t_clr), W'(1));
        chk("seq_t_en", W'(t_en), W'(2));
        chk("seq_n_clr", W'(n_clr), W'(1));
        chk("seq_n_en", W'(n_en), W'(1));
        chk("seq_ecc_op", W'(ecc_op), W'(2'b10));
        chk("rd_latency", W'(t_rdv - t_rise), W'(1));
        chk("rd_count", W'(got_q.size()), W'(64));
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] == ((i < 32) ? 8'hAA : 8'h55)) cnt++;
        chk("rd_bytes_aa55", W'(cnt), W'(64));
        chk("rd_consecutive", W'(t_last - t_first), W'(63));
        chk("end_done", W'(done), W'(1));
        chk("end_busy", W'(busy), W'(0));

        // Backpressure with rd_ready toggling
        x = rnd_w(); y = rnd_w();
        run_op(2'b01, 1'b1, 3, 1, 1'b0, 1'b0);
        xy = {x, y};
        cnt = 0;
        foreach (got_q[i]) if (got_q[i] != xy[8*(NB-1-i) +: 8]) cnt++;
        chk("bp_count", W'(got_q.size()), W'(64));
        chk("bp_bad_bytes", W'(cnt), W'(0));

        // Loads and starts while busy are ignored
        run_op(2'b11, 1'b1, 4, 2, 1'b1, 1'b0);
        chk("busy_ld_Qx", Qx, QX_LIT);
        chk("busy_ld_Qy", Qy, '0);

        // Timeout: ready never drops
        run_op(2'b00, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("to_err", W'(err), W'(1));
        chk("to_done", W'(done), W'(0));
        chk("to_busy", W'(busy), W'(0));
        chk("to_latency", W'(t_err - t_en), W'(17));
        chk("to_no_bytes", W'(got_q.size()), W'(0));
        run_op(2'b01, 1'b1, 2, 0, 1'b0, 1'b0);
        chk("to_restart_clears_err", W'(e1), W'(0));

        // Reset while waiting for ready high
        @(negedge clk); start = 1'b1; op = 2'b11;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("rstw_en", W'(ecc_en), W'(1));
        ecc_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw_busy_pre", W'(busy), W'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ecc_rdy = 1'b1;
        chk("rstw_busy", W'(busy), W'(0));
        chk("rstw_ctl", W'({ecc_en, ecc_clr, ecc_op}), W'(0));
        chk("rstw_status", W'({done, err, rd_valid}), W'(0));
        chk("rstw_Qx", Qx, '0);

        // Randomized operations
        for (int it = 0; it < 25; it++) begin
            do_loads($urandom_range(0, 8));
            x = rnd_w(); y = rnd_w();
            run_op(2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 20), $urandom_range(0, 2),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
